// File: rtl/face_detect_pkg.sv
// face_detect_pkg
//   Shared types and grid constants for the downscaled XYZ frame path that
//   feeds the face-detection window classifier.
//   Contents:
//     GRID_W / GRID_H / GRID_CELLS  scaled grid geometry
//     ADDR_W / DATA_W / COORD_W     buffer address, component and coordinate widths
//     pixel_xyz_t                   one X/Y/Z sample
//     grid_coord_t                  column/row of a cell
//     pixel_beat_t                  sample + coordinate + frame markers
//     reader_state_e                frame reader FSM states
package face_detect_pkg;

  localparam int GRID_W     = 20;
  localparam int GRID_H     = 20;
  localparam int GRID_CELLS = GRID_W * GRID_H;
  localparam int ADDR_W     = 9;
  localparam int DATA_W     = 8;
  localparam int COORD_W    = 5;

  typedef struct packed {
    logic [DATA_W-1:0] x;
    logic [DATA_W-1:0] y;
    logic [DATA_W-1:0] z;
  } pixel_xyz_t;

  typedef struct packed {
    logic [COORD_W-1:0] col;
    logic [COORD_W-1:0] row;
  } grid_coord_t;

  typedef struct packed {
    pixel_xyz_t  pix;
    grid_coord_t coord;
    logic        sof;
    logic        eol;
    logic        eof;
  } pixel_beat_t;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DRAIN
  } reader_state_e;

endpackage

// File: rtl/pixel_skid_buffer.sv
// pixel_skid_buffer
//   Two-entry FIFO of pixel beats sitting between the 1-cycle-latency buffer
//   read and the valid/ready pixel output. Two entries let the reader keep one
//   read in flight while the head is stalled, giving full throughput without
//   ever dropping a returned sample.
//   Ports:
//     clk, rst  clock and asynchronous active-high reset
//     push      write din this cycle (caller guarantees space)
//     pop       drop head this cycle (caller guarantees valid)
//     din       incoming beat
//     head      oldest stored beat
//     valid     head holds a beat
//     count     occupancy 0..2
module pixel_skid_buffer
  import face_detect_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  logic        pop,
  input  pixel_beat_t din,
  output pixel_beat_t head,
  output logic        valid,
  output logic [1:0]  count
);

  pixel_beat_t mem [2];
  logic        wr_ptr;
  logic        rd_ptr;

  // Storage, pointers and occupancy; push and pop may coincide.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  assign head  = mem[rd_ptr];
  assign valid = (count != 2'd0);

endmodule

// File: rtl/scaled_frame_reader.sv
// scaled_frame_reader
//   Read-side master for the downscaled XYZ frame buffer. A START pulse sweeps
//   the buffer read port over all GRID_W x GRID_H cells in raster order and
//   streams one pixel per valid/ready beat with row/col and SOF/EOL/EOF markers.
//   Optional feature macro: SCALED_READER_STATS_EN adds Y_SUM / STATS_VALID.
//   Ports:
//     CLK, RESET            clock, asynchronous active-high reset
//     START                 frame-complete pulse from the scaler
//     RD_EN, RD_ADDR        buffer read port (address = row*GRID_W+col)
//     X_IN, Y_IN, Z_IN      buffer data for RD_ADDR, sampled one edge later
//     PIX_VALID, PIX_READY  output handshake
//     PIX_X/Y/Z             pixel components
//     PIX_COL, PIX_ROW      cell coordinate of the beat
//     PIX_SOF/EOL/EOF       first cell / last column / last cell markers
//     BUSY                  frame in progress
//     OVERRUN               sticky: START seen while busy
//     Y_SUM, STATS_VALID    (stats build only) Y sum of the frame, done pulse
module scaled_frame_reader
  import face_detect_pkg::*;
(
  input  logic              CLK,
  input  logic              RESET,
  input  logic              START,
  output logic              RD_EN,
  output logic [ADDR_W-1:0] RD_ADDR,
  input  logic [DATA_W-1:0] X_IN,
  input  logic [DATA_W-1:0] Y_IN,
  input  logic [DATA_W-1:0] Z_IN,
  output logic              PIX_VALID,
  input  logic              PIX_READY,
  output logic [DATA_W-1:0] PIX_X,
  output logic [DATA_W-1:0] PIX_Y,
  output logic [DATA_W-1:0] PIX_Z,
  output logic [4:0]        PIX_COL,
  output logic [4:0]        PIX_ROW,
  output logic              PIX_SOF,
  output logic              PIX_EOL,
  output logic              PIX_EOF,
  output logic              BUSY,
  output logic              OVERRUN
`ifdef SCALED_READER_STATS_EN
  ,
  output logic [16:0]       Y_SUM,
  output logic              STATS_VALID
`endif
);

  localparam logic [ADDR_W-1:0]  PENULT_ADDR = ADDR_W'(GRID_CELLS - 2);
  localparam logic [COORD_W-1:0] LAST_COL    = COORD_W'(GRID_W - 1);
  localparam logic [COORD_W-1:0] LAST_ROW    = COORD_W'(GRID_H - 1);

  reader_state_e      state;
  logic [COORD_W-1:0] iss_col;
  logic [COORD_W-1:0] iss_row;
  pixel_beat_t        push_beat;
  pixel_beat_t        head;
  logic [1:0]         occ;
  logic [1:0]         occ_next;
  logic               pop;
  logic               issue_ok;

  // The returning read carries the coordinate registered alongside RD_ADDR,
  // since both describe the read that is in flight this cycle.
  always_comb begin
    push_beat           = '0;
    push_beat.pix.x     = X_IN;
    push_beat.pix.y     = Y_IN;
    push_beat.pix.z     = Z_IN;
    push_beat.coord.col = iss_col;
    push_beat.coord.row = iss_row;
    push_beat.sof       = (RD_ADDR == '0);
    push_beat.eol       = (iss_col == LAST_COL);
    push_beat.eof       = (iss_col == LAST_COL) && (iss_row == LAST_ROW);
  end

  // Occupancy after this edge; a new read may only be issued if the skid
  // will still have a free slot for it when its data returns.
  assign pop      = PIX_VALID & PIX_READY;
  assign occ_next = occ + {1'b0, RD_EN} - {1'b0, pop};
  assign issue_ok = (occ_next < 2'd2);

  pixel_skid_buffer u_skid (
    .clk   (CLK),
    .rst   (RESET),
    .push  (RD_EN),
    .pop   (pop),
    .din   (push_beat),
    .head  (head),
    .valid (PIX_VALID),
    .count (occ)
  );

  assign PIX_X   = head.pix.x;
  assign PIX_Y   = head.pix.y;
  assign PIX_Z   = head.pix.z;
  assign PIX_COL = head.coord.col;
  assign PIX_ROW = head.coord.row;
  assign PIX_SOF = head.sof;
  assign PIX_EOL = head.eol;
  assign PIX_EOF = head.eof;

  // Frame sequencer. RD_ADDR always holds the most recently issued address,
  // so every later issue is simply RD_ADDR+1 with the coordinate stepping in
  // raster order. DRAIN waits for the skid to empty before going idle.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state   <= IDLE;
      RD_EN   <= 1'b0;
      RD_ADDR <= '0;
      iss_col <= '0;
      iss_row <= '0;
      BUSY    <= 1'b0;
      OVERRUN <= 1'b0;
    end else begin
      if (START && (state != IDLE)) begin
        OVERRUN <= 1'b1;
      end
      case (state)
        IDLE: begin
          RD_EN <= 1'b0;
          if (START) begin
            state   <= STREAM;
            RD_EN   <= 1'b1;
            RD_ADDR <= '0;
            iss_col <= '0;
            iss_row <= '0;
            BUSY    <= 1'b1;
          end
        end
        STREAM: begin
          if (issue_ok) begin
            RD_EN   <= 1'b1;
            RD_ADDR <= RD_ADDR + 1'b1;
            if (iss_col == LAST_COL) begin
              iss_col <= '0;
              iss_row <= iss_row + 1'b1;
            end else begin
              iss_col <= iss_col + 1'b1;
            end
            if (RD_ADDR == PENULT_ADDR) begin
              state <= DRAIN;
            end
          end else begin
            RD_EN <= 1'b0;
          end
        end
        DRAIN: begin
          RD_EN <= 1'b0;
          if (occ_next == 2'd0) begin
            state <= IDLE;
            BUSY  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          RD_EN <= 1'b0;
          BUSY  <= 1'b0;
        end
      endcase
    end
  end

`ifdef SCALED_READER_STATS_EN
  // Frame Y statistics: cleared when a START is accepted, accumulated on each
  // accepted beat, announced the cycle after the EOF beat leaves.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      Y_SUM       <= '0;
      STATS_VALID <= 1'b0;
    end else begin
      STATS_VALID <= pop & head.eof;
      if ((state == IDLE) && START) begin
        Y_SUM <= '0;
      end else if (pop) begin
        Y_SUM <= Y_SUM + 17'(head.pix.y);
      end
    end
  end
`endif

endmodule

// File: tb/tb_scaled_frame_reader.sv
// tb_scaled_frame_reader
//   Directed bench for scaled_frame_reader. The frame buffer is modelled
//   combinationally: X = addr+3, Y = addr, Z = ~addr (all mod 256), so every
//   beat n of a frame has a known expected value.
//   Optional feature macro: SCALED_READER_STATS_EN enables the Y_SUM checks.
module tb_scaled_frame_reader;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       START;
  logic       RD_EN;
  logic [8:0] RD_ADDR;
  logic [7:0] X_IN, Y_IN, Z_IN;
  logic       PIX_VALID;
  logic       PIX_READY;
  logic [7:0] PIX_X, PIX_Y, PIX_Z;
  logic [4:0] PIX_COL, PIX_ROW;
  logic       PIX_SOF, PIX_EOL, PIX_EOF;
  logic       BUSY;
  logic       OVERRUN;
`ifdef SCALED_READER_STATS_EN
  logic [16:0] Y_SUM;
  logic        STATS_VALID;
`endif

  int checks = 0;
  int errors = 0;

  logic [36:0] obs;

  always #5 CLK = ~CLK;

  assign X_IN = RD_ADDR[7:0] + 8'd3;
  assign Y_IN = RD_ADDR[7:0];
  assign Z_IN = ~RD_ADDR[7:0];

  assign obs = {PIX_X, PIX_Y, PIX_Z, PIX_COL, PIX_ROW, PIX_SOF, PIX_EOL, PIX_EOF};

  scaled_frame_reader dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .START       (START),
    .RD_EN       (RD_EN),
    .RD_ADDR     (RD_ADDR),
    .X_IN        (X_IN),
    .Y_IN        (Y_IN),
    .Z_IN        (Z_IN),
    .PIX_VALID   (PIX_VALID),
    .PIX_READY   (PIX_READY),
    .PIX_X       (PIX_X),
    .PIX_Y       (PIX_Y),
    .PIX_Z       (PIX_Z),
    .PIX_COL     (PIX_COL),
    .PIX_ROW     (PIX_ROW),
    .PIX_SOF     (PIX_SOF),
    .PIX_EOL     (PIX_EOL),
    .PIX_EOF     (PIX_EOF),
    .BUSY        (BUSY),
    .OVERRUN     (OVERRUN)
`ifdef SCALED_READER_STATS_EN
    ,
    .Y_SUM       (Y_SUM),
    .STATS_VALID (STATS_VALID)
`endif
  );

  // Expected beat n of a 20x20 frame under the buffer model above.
  function automatic logic [36:0] exp_beat(input int n);
    logic [7:0] a;
    a = n[7:0];
    return {a + 8'd3, a, ~a, 5'(n % 20), 5'(n / 20),
            (n == 0), (n % 20 == 19), (n == 399)};
  endfunction

  // One-cycle START pulse; returns at the falling edge after START's edge.
  task automatic pulse_start();
    @(negedge CLK);
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    repeat (3) @(negedge CLK);
    checks++;
    if ({PIX_VALID, BUSY, RD_EN, OVERRUN} !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL reset_flags got %b want 0000", {PIX_VALID, BUSY, RD_EN, OVERRUN});
    end
    checks++;
    if (RD_ADDR !== 9'd0) begin
      errors++;
      $display("[TB] FAIL reset_addr got %0d want 0", RD_ADDR);
    end
    checks++;
    if (obs !== 37'd0) begin
      errors++;
      $display("[TB] FAIL reset_pix got %h want 0", obs);
    end
`ifdef SCALED_READER_STATS_EN
    checks++;
    if ({Y_SUM, STATS_VALID} !== 18'd0) begin
      errors++;
      $display("[TB] FAIL reset_stats got %h want 0", {Y_SUM, STATS_VALID});
    end
`endif
    RESET = 1'b0;
    repeat (2) @(negedge CLK);
    checks++;
    if ({PIX_VALID, BUSY, RD_EN} !== 3'b000) begin
      errors++;
      $display("[TB] FAIL idle_after_reset got %b want 000", {PIX_VALID, BUSY, RD_EN});
    end
  endtask

  task automatic test_full_rate();
    int sofs, eols, eofs;
    sofs = 0; eols = 0; eofs = 0;
    PIX_READY = 1'b1;
    pulse_start();
    checks++;
    if ({BUSY, RD_EN, RD_ADDR, PIX_VALID} !== {1'b1, 1'b1, 9'd0, 1'b0}) begin
      errors++;
      $display("[TB] FAIL start_issue got busy=%b rd_en=%b addr=%0d valid=%b want 1 1 0 0",
               BUSY, RD_EN, RD_ADDR, PIX_VALID);
    end
    for (int n = 0; n < 400; n++) begin
      @(negedge CLK);
      checks++;
      if ({PIX_VALID, obs} !== {1'b1, exp_beat(n)}) begin
        errors++;
        $display("[TB] FAIL full_beat%0d got v=%b %h want v=1 %h", n, PIX_VALID, obs, exp_beat(n));
      end
      if (PIX_VALID) begin
        sofs += int'(PIX_SOF);
        eols += int'(PIX_EOL);
        eofs += int'(PIX_EOF);
      end
    end
    @(negedge CLK);
    checks++;
    if ({PIX_VALID, BUSY} !== 2'b00) begin
      errors++;
      $display("[TB] FAIL full_end got valid=%b busy=%b want 0 0", PIX_VALID, BUSY);
    end
    checks++;
    if ({sofs, eols, eofs} !== {32'd1, 32'd20, 32'd1}) begin
      errors++;
      $display("[TB] FAIL marker_counts got sof=%0d eol=%0d eof=%0d want 1 20 1", sofs, eols, eofs);
    end
  endtask

  task automatic test_backpressure();
    int accepted, issued, cyc, max_out;
    logic stalled;
    logic ready;
    logic [36:0] last_obs;
    accepted = 0; issued = 0; cyc = 0; max_out = 0;
    stalled = 1'b0;
    last_obs = '0;
    PIX_READY = 1'b0;
    pulse_start();
    while ((accepted < 400) && (cyc < 4000)) begin
      if (RD_EN) begin
        checks++;
        if (RD_ADDR !== 9'(issued)) begin
          errors++;
          $display("[TB] FAIL bp_addr got %0d want %0d", RD_ADDR, issued);
        end
        issued++;
      end
      if (issued - accepted > max_out) max_out = issued - accepted;
      if (stalled) begin
        checks++;
        if ({PIX_VALID, obs} !== {1'b1, last_obs}) begin
          errors++;
          $display("[TB] FAIL bp_stable got v=%b %h want v=1 %h", PIX_VALID, obs, last_obs);
        end
      end
      ready = ($urandom_range(0, 99) >= 30);
      PIX_READY = ready;
      if (PIX_VALID && ready) begin
        checks++;
        if (obs !== exp_beat(accepted)) begin
          errors++;
          $display("[TB] FAIL bp_beat%0d got %h want %h", accepted, obs, exp_beat(accepted));
        end
        accepted++;
      end
      stalled = PIX_VALID && !ready;
      last_obs = obs;
      @(negedge CLK);
      cyc++;
    end
    PIX_READY = 1'b1;
    checks++;
    if ((accepted != 400) || (issued != 400)) begin
      errors++;
      $display("[TB] FAIL bp_count got accepted=%0d issued=%0d want 400 400", accepted, issued);
    end
    checks++;
    if (max_out > 2) begin
      errors++;
      $display("[TB] FAIL bp_outstanding got %0d want <=2", max_out);
    end
    checks++;
    if ({PIX_VALID, BUSY} !== 2'b00) begin
      errors++;
      $display("[TB] FAIL bp_end got valid=%b busy=%b want 0 0", PIX_VALID, BUSY);
    end
  endtask

  task automatic test_overrun();
    logic any_valid;
    any_valid = 1'b0;
    checks++;
    if (OVERRUN !== 1'b0) begin
      errors++;
      $display("[TB] FAIL overrun_pre got %b want 0", OVERRUN);
    end
    PIX_READY = 1'b1;
    pulse_start();
    for (int n = 0; n < 400; n++) begin
      @(negedge CLK);
      START = (n == 50);
      checks++;
      if ({PIX_VALID, obs} !== {1'b1, exp_beat(n)}) begin
        errors++;
        $display("[TB] FAIL ovr_beat%0d got v=%b %h want v=1 %h", n, PIX_VALID, obs, exp_beat(n));
      end
    end
    START = 1'b0;
    checks++;
    if (OVERRUN !== 1'b1) begin
      errors++;
      $display("[TB] FAIL overrun_set got %b want 1", OVERRUN);
    end
    repeat (10) begin
      @(negedge CLK);
      any_valid = any_valid | PIX_VALID | BUSY;
    end
    checks++;
    if (any_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL ovr_no_restart got %b want 0", any_valid);
    end
    checks++;
    if (OVERRUN !== 1'b1) begin
      errors++;
      $display("[TB] FAIL overrun_sticky got %b want 1", OVERRUN);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic any_valid;
    any_valid = 1'b0;
    PIX_READY = 1'b1;
    pulse_start();
    for (int n = 0; n < 138; n++) begin
      @(negedge CLK);
      checks++;
      if ({PIX_VALID, obs} !== {1'b1, exp_beat(n)}) begin
        errors++;
        $display("[TB] FAIL mid_beat%0d got v=%b %h want v=1 %h", n, PIX_VALID, obs, exp_beat(n));
      end
    end
    RESET = 1'b1;
    #1;
    checks++;
    if ({PIX_VALID, BUSY, RD_EN, OVERRUN} !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL mid_reset got %b want 0000", {PIX_VALID, BUSY, RD_EN, OVERRUN});
    end
    @(negedge CLK);
    RESET = 1'b0;
    repeat (5) begin
      @(negedge CLK);
      any_valid = any_valid | PIX_VALID | BUSY | RD_EN;
    end
    checks++;
    if (any_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL mid_quiet got %b want 0", any_valid);
    end
    pulse_start();
`ifdef SCALED_READER_STATS_EN
    checks++;
    if (Y_SUM !== 17'd0) begin
      errors++;
      $display("[TB] FAIL stats_clear got %0d want 0", Y_SUM);
    end
`endif
    for (int n = 0; n < 400; n++) begin
      @(negedge CLK);
      checks++;
      if ({PIX_VALID, obs} !== {1'b1, exp_beat(n)}) begin
        errors++;
        $display("[TB] FAIL rst_frame_beat%0d got v=%b %h want v=1 %h", n, PIX_VALID, obs, exp_beat(n));
      end
`ifdef SCALED_READER_STATS_EN
      checks++;
      if (STATS_VALID !== 1'b0) begin
        errors++;
        $display("[TB] FAIL stats_early got %b want 0", STATS_VALID);
      end
`endif
    end
    @(negedge CLK);
    checks++;
    if ({PIX_VALID, BUSY} !== 2'b00) begin
      errors++;
      $display("[TB] FAIL rst_frame_end got valid=%b busy=%b want 0 0", PIX_VALID, BUSY);
    end
`ifdef SCALED_READER_STATS_EN
    // Y = addr mod 256: sum(0..255) + sum(0..143) = 32640 + 10296 = 42936.
    checks++;
    if ({STATS_VALID, Y_SUM} !== {1'b1, 17'd42936}) begin
      errors++;
      $display("[TB] FAIL stats_done got v=%b sum=%0d want v=1 sum=42936", STATS_VALID, Y_SUM);
    end
    @(negedge CLK);
    checks++;
    if ({STATS_VALID, Y_SUM} !== {1'b0, 17'd42936}) begin
      errors++;
      $display("[TB] FAIL stats_hold got v=%b sum=%0d want v=0 sum=42936", STATS_VALID, Y_SUM);
    end
`endif
  endtask

  initial begin
    RESET     = 1'b1;
    START     = 1'b0;
    PIX_READY = 1'b0;
    test_reset();
    test_full_rate();
    test_backpressure();
    test_overrun();
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
